sharpen_window_gen: RTL

- Streaming 3x3 window generator that sits directly upstream of the image-sharpening kernel stage.
- Accepts one raster-order grayscale pixel per handshake and buffers the two previous image rows in on-chip line buffers.
- Emits one 3x3 neighbourhood per interior pixel, in the w0..w8 order the sharpening kernel consumes (same order as its db0..db8 debug taps).
- Border pixels get no window; the downstream stage handles the frame edge.

---
 rtl/sharpen_window_gen.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/sharpen_window_gen.sv
// ---------------------------------------------------------------------------
// sharpen_window_gen
//
// Streaming 3x3 window generator feeding the image-sharpening kernel. It takes
// one raster-order pixel per handshake, keeps the two previous rows in line
// buffers, and emits one 3x3 neighbourhood per interior pixel (border pixels
// produce no window).
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous active-low reset (0 = in reset)
//   in_valid   in_pix holds a valid pixel
//   in_ready   block accepts in_pix this cycle
//   in_pix     raster-order pixel, row 0 col 0 first
//   win_valid  w0..w8 hold a valid window
//   win_ready  downstream accepts the window this cycle
//   w0..w8     window, row-major: w0=(x-1,y-1), w4=(x,y), w8=(x+1,y+1)
//   win_x      centre column of the current window
//   win_y      centre row of the current window
//   frame_done one-cycle pulse after the last window of a frame is consumed
//   win_cnt    (SHARPEN_WINGEN_STATS_EN only) consumed windows this frame
//
// Optional feature macro: SHARPEN_WINGEN_STATS_EN adds the saturating 20-bit
// win_cnt output. When undefined the port and its counter are absent.
// ---------------------------------------------------------------------------
module sharpen_window_gen #(
  parameter int IMG_W = 800,
  parameter int IMG_H = 600,
  parameter int PIX_W = 8,
  parameter int CW    = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PIX_W-1:0] in_pix,
  output logic             win_valid,
  input  logic             win_ready,
  output logic [PIX_W-1:0] w0,
  output logic [PIX_W-1:0] w1,
  output logic [PIX_W-1:0] w2,
  output logic [PIX_W-1:0] w3,
  output logic [PIX_W-1:0] w4,
  output logic [PIX_W-1:0] w5,
  output logic [PIX_W-1:0] w6,
  output logic [PIX_W-1:0] w7,
  output logic [PIX_W-1:0] w8,
  output logic [CW-1:0]    win_x,
  output logic [CW-1:0]    win_y,
  output logic             frame_done
`ifdef SHARPEN_WINGEN_STATS_EN
  ,
  output logic [19:0]      win_cnt
`endif
);

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    STREAM = 2'd1,
    LAST   = 2'd2
  } state_t;

  state_t state;

  logic [CW-1:0] px;
  logic [CW-1:0] py;

  // lb1 holds row py-1, lb2 holds row py-2
  logic [PIX_W-1:0] lb1 [IMG_W];
  logic [PIX_W-1:0] lb2 [IMG_W];

  // Column shift registers, index 0 is the leftmost (oldest) column
  logic [PIX_W-1:0] col_top [3];
  logic [PIX_W-1:0] col_mid [3];
  logic [PIX_W-1:0] col_bot [3];
  logic [PIX_W-1:0] nxt_top [3];
  logic [PIX_W-1:0] nxt_mid [3];
  logic [PIX_W-1:0] nxt_bot [3];

  logic             acc;
  logic             emit;
  logic             last_col;
  logic             last_row;
  logic [PIX_W-1:0] rd1;
  logic [PIX_W-1:0] rd2;

  // Handshake: a single output register, so the input may advance whenever
  // the window slot is empty or being drained. Input is frozen while the
  // final window of the frame is still waiting to be taken.
  assign in_ready = (state != LAST) && (!win_valid || win_ready);
  assign acc      = in_valid && in_ready;
  assign last_col = (px == CW'(IMG_W - 1));
  assign last_row = (py == CW'(IMG_H - 1));
  assign emit     = acc && (px >= CW'(2)) && (py >= CW'(2));

  // Read-before-write: both reads see the data stored before this accept
  assign rd1 = lb1[px];
  assign rd2 = lb2[px];

  // Line buffers roll one row down on every accept; contents need no reset
  always_ff @(posedge clk) begin
    if (acc) begin
      lb2[px] <= rd1;
      lb1[px] <= in_pix;
    end
  end

  // Next column contents: shift left and bring in the new column. At the
  // start of a row the stale columns from the previous row are flushed.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      nxt_top[i] = col_top[i];
      nxt_mid[i] = col_mid[i];
      nxt_bot[i] = col_bot[i];
    end
    if (px == '0) begin
      nxt_top[0] = '0;
      nxt_mid[0] = '0;
      nxt_bot[0] = '0;
      nxt_top[1] = '0;
      nxt_mid[1] = '0;
      nxt_bot[1] = '0;
    end else begin
      nxt_top[0] = col_top[1];
      nxt_mid[0] = col_mid[1];
      nxt_bot[0] = col_bot[1];
      nxt_top[1] = col_top[2];
      nxt_mid[1] = col_mid[2];
      nxt_bot[1] = col_bot[2];
    end
    nxt_top[2] = rd2;
    nxt_mid[2] = rd1;
    nxt_bot[2] = in_pix;
  end

  // Main sequencer: pixel counters, column registers, window output register
  // and the FILL/STREAM/LAST frame state. The counters are returned to zero
  // at the final pixel's accept; LAST then only waits for the final window.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= FILL;
      px         <= '0;
      py         <= '0;
      win_valid  <= 1'b0;
      win_x      <= '0;
      win_y      <= '0;
      frame_done <= 1'b0;
      w0 <= '0; w1 <= '0; w2 <= '0;
      w3 <= '0; w4 <= '0; w5 <= '0;
      w6 <= '0; w7 <= '0; w8 <= '0;
      for (int i = 0; i < 3; i++) begin
        col_top[i] <= '0;
        col_mid[i] <= '0;
        col_bot[i] <= '0;
      end
    end else begin
      frame_done <= 1'b0;

      if (acc) begin
        for (int i = 0; i < 3; i++) begin
          col_top[i] <= nxt_top[i];
          col_mid[i] <= nxt_mid[i];
          col_bot[i] <= nxt_bot[i];
        end
        if (last_col) begin
          px <= '0;
          if (last_row) begin
            py    <= '0;
            state <= LAST;
          end else begin
            py <= py + CW'(1);
            if (py == CW'(1)) begin
              state <= STREAM;
            end
          end
        end else begin
          px <= px + CW'(1);
        end
      end

      if (emit) begin
        win_valid <= 1'b1;
        win_x     <= px - CW'(1);
        win_y     <= py - CW'(1);
        w0 <= nxt_top[0]; w1 <= nxt_top[1]; w2 <= nxt_top[2];
        w3 <= nxt_mid[0]; w4 <= nxt_mid[1]; w5 <= nxt_mid[2];
        w6 <= nxt_bot[0]; w7 <= nxt_bot[1]; w8 <= nxt_bot[2];
      end else if (win_ready) begin
        win_valid <= 1'b0;
      end

      if ((state == LAST) && win_valid && win_ready) begin
        frame_done <= 1'b1;
        state      <= FILL;
      end
    end
  end

`ifdef SHARPEN_WINGEN_STATS_EN
  // Consumed-window counter for the current frame; it holds its final value
  // during the frame_done cycle and clears right after it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      win_cnt <= '0;
    end else if (frame_done) begin
      win_cnt <= '0;
    end else if (win_valid && win_ready && (win_cnt != 20'hFFFFF)) begin
      win_cnt <= win_cnt + 20'd1;
    end
  end
`endif

endmodule
